store_buffer: RTL and testbench

- Sits directly upstream of the data memory, between the EX/MEM pipeline register and the memory's single shared address port.
- Queues committed stores in a small FIFO and drains them into memory one word per cycle whenever the port is not needed by a load.
- Forwards buffered store data to younger loads, and stalls loads that partially overlap a pending store.

---
 rtl/store_buffer.sv | 117 +++++++++++
 tb/tb_store_buffer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer between EX/MEM and a single-port data memory: queues stores,
// drains them when the port is free, forwards to loads, stalls partial hits.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  output logic [DW-1:0] ld_data,
  output logic          ld_stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;
  logic [PW-1:0]    idx;

  logic          full;
  logic          push;
  logic          pop;
  logic          rd;
  logic          hit;
  logic          part;
  logic [DW-1:0] fwd;

  function automatic logic near(
    input logic [AW-1:0] a,
    input logic [AW-1:0] b
  );
    logic [AW:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[AW]) d = -d;
    return d < (AW+1)'(4);
  endfunction

  // Walk oldest to youngest so the last overlapping entry wins.
  always_comb begin
    hit  = 1'b0;
    part = 1'b0;
    fwd  = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (ent_vld[idx] && near(ent_addr[idx], ld_addr)) begin
        hit  = (ent_addr[idx] == ld_addr);
        part = (ent_addr[idx] != ld_addr);
        fwd  = ent_data[idx];
      end
    end
  end

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign st_ready = !full;

  // A full buffer with a waiting store must drain even under load traffic.
  assign ld_stall = ld_req && (part || (full && st_valid));
  assign rd       = ld_req && !ld_stall;
  assign pop      = !rd && !empty;
  assign push     = st_valid && !full;

  assign mem_read  = rd;
  assign mem_write = pop;
  assign mem_addr  = rd ? ld_addr : (pop ? ent_addr[head] : '0);
  assign mem_wdata = pop ? ent_data[head] : '0;
  assign ld_data   = hit ? fwd : mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        head          <= head + 1'b1;
        ent_vld[head] <= 1'b0;
      end
      if (push) begin
        tail          <= tail + 1'b1;
        ent_vld[tail] <= 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= st_addr;
      ent_data[tail] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: byte memory on the port, queue-based reference
// model, directed scenarios plus randomized traffic.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        empty;

  int nchk = 0;
  int nerr = 0;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_stall(ld_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .empty(empty)
  );

  always #5 clk = ~clk;

  logic [7:0] mem  [256];
  logic [7:0] mref [256];

  always @(negedge clk) begin
    if (mem_write)
      for (int j = 0; j < 4; j++)
        mem[mem_addr[7:0] + 8'(j)] = mem_wdata[31-8*j -: 8];
  end

  assign mem_rdata = {mem[mem_addr[7:0]], mem[mem_addr[7:0] + 8'd1],
                      mem[mem_addr[7:0] + 8'd2], mem[mem_addr[7:0] + 8'd3]};

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  logic        e_ready, e_empty, e_stall, e_read, e_write, e_push;
  logic [31:0] e_addr, e_wdata, e_ld;

  function automatic bit near(logic [31:0] a, logic [31:0] b);
    longint d;
    d = longint'(a) - longint'(b);
    return (d > -4) && (d < 4);
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {mref[b], mref[b + 8'd1], mref[b + 8'd2], mref[b + 8'd3]};
  endfunction

  // Drive one cycle's inputs and work out what the port should do.
  task automatic drive(input logic sv, input logic [31:0] sa,
                       input logic [31:0] sd, input logic lr,
                       input logic [31:0] la);
    bit full, hit, part;
    logic [31:0] hd;
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_req = lr; ld_addr = la;
    #2;
    full = (q.size() == 4);
    hit = 0; part = 0; hd = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (near(q[i].a, la)) begin
        if (q[i].a == la) begin hit = 1; hd = q[i].d; end
        else part = 1;
        break;
      end
    end
    e_ready = !full;
    e_empty = (q.size() == 0);
    e_stall = lr && (part || (full && sv));
    e_read  = lr && !e_stall;
    e_write = !e_read && (q.size() != 0);
    e_addr  = e_read ? la : (e_write ? q[0].a : 32'h0);
    e_wdata = e_write ? q[0].d : 32'h0;
    e_ld    = hit ? hd : ref_word(la);
    e_push  = sv && !full;
  endtask

  task automatic tick();
    ent_t e;
    @(posedge clk);
    #1;
    if (e_write) begin
      e = q.pop_front();
      for (int j = 0; j < 4; j++)
        mref[e.a[7:0] + 8'(j)] = e.d[31-8*j -: 8];
    end
    if (e_push) begin
      e.a = st_addr; e.d = st_data;
      q.push_back(e);
    end
  endtask

  task automatic settle();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      drive(0, 0, 0, 0, 0);
      tick();
      n++;
    end
    drive(0, 0, 0, 0, 0);
    nchk++;
    if (empty !== 1'b1) begin
      nerr++;
      $display("FAIL settle_empty: got %b want 1", empty);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    st_valid = 0; st_addr = 0; st_data = 0; ld_req = 0; ld_addr = 0;
    #2;
    nchk++;
    if ({st_ready, empty, ld_stall, mem_write, mem_read} !== 5'b11000) begin
      nerr++;
      $display("FAIL reset_outputs: got %b want 11000",
               {st_ready, empty, ld_stall, mem_write, mem_read});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_basic();
    drive(1, 32'h10, 32'hDEADBEEF, 0, 0);
    nchk++;
    if (mem_write !== 1'b0) begin
      nerr++;
      $display("FAIL basic_no_early_write: got %b want 0", mem_write);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    nchk++;
    if ({mem_write, mem_addr, mem_wdata} !== {1'b1, 32'h10, 32'hDEADBEEF}) begin
      nerr++;
      $display("FAIL basic_drain: got %b %h %h want 1 00000010 deadbeef",
               mem_write, mem_addr, mem_wdata);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    nchk++;
    if ({empty, mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}
        !== {1'b1, 32'hDEADBEEF}) begin
      nerr++;
      $display("FAIL basic_mem: got %b %h%h%h%h want 1 deadbeef", empty,
               mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]);
    end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h30 + 32'(4 * i), 32'h30000000 + 32'(i), 1, 32'h70);
      nchk++;
      if ({st_ready, ld_stall, mem_read, mem_write} !== 4'b1010) begin
        nerr++;
        $display("FAIL fill_push%0d: got %b want 1010", i,
                 {st_ready, ld_stall, mem_read, mem_write});
      end
      tick();
    end
    drive(1, 32'h50, 32'h55555555, 1, 32'h70);
    nchk++;
    if ({st_ready, ld_stall, mem_write, mem_addr} !== {3'b011, 32'h30}) begin
      nerr++;
      $display("FAIL fill_guard: got %b%b%b %h want 011 00000030",
               st_ready, ld_stall, mem_write, mem_addr);
    end
    tick();
    drive(1, 32'h50, 32'h55555555, 0, 0);
    nchk++;
    if (st_ready !== 1'b1) begin
      nerr++;
      $display("FAIL fill_ready_back: got %b want 1", st_ready);
    end
    tick();
    settle();
  endtask

  task automatic test_forward();
    drive(1, 32'h20, 32'h11111111, 0, 0);
    tick();
    drive(1, 32'h20, 32'h22222222, 0, 0);
    tick();
    drive(0, 0, 0, 1, 32'h20);
    nchk++;
    if ({ld_data, ld_stall, mem_write} !== {32'h22222222, 2'b00}) begin
      nerr++;
      $display("FAIL forward_youngest: got %h %b %b want 22222222 0 0",
               ld_data, ld_stall, mem_write);
    end
    tick();
    settle();
  endtask

  task automatic test_overlap();
    drive(1, 32'h40, 32'hAABBCCDD, 0, 0);
    tick();
    drive(0, 0, 0, 1, 32'h42);
    nchk++;
    if ({ld_stall, mem_read, mem_write, mem_addr} !== {3'b101, 32'h40}) begin
      nerr++;
      $display("FAIL overlap_stall: got %b%b%b %h want 101 00000040",
               ld_stall, mem_read, mem_write, mem_addr);
    end
    tick();
    drive(0, 0, 0, 1, 32'h42);
    nchk++;
    if ({ld_stall, ld_data} !== {1'b0, 32'hCCDD0000}) begin
      nerr++;
      $display("FAIL overlap_after: got %b %h want 0 ccdd0000",
               ld_stall, ld_data);
    end
    tick();
    settle();
  endtask

  task automatic test_wrap();
    logic [31:0] a, w0, w1, w2;
    bit acc;
    int tries;
    for (int i = 0; i < 10; i++) begin
      a = 32'h60 + 32'(4 * (i % 3));
      tries = 0;
      do begin
        drive(1, a, 32'h10000000 + 32'(i), (i % 2) == 0,
              32'h60 + 32'(4 * ((i + 1) % 3)));
        nchk++;
        if ({st_ready, empty, ld_stall, mem_write, mem_read}
            !== {e_ready, e_empty, e_stall, e_write, e_read}) begin
          nerr++;
          $display("FAIL wrap_status%0d: got %b want %b", i,
                   {st_ready, empty, ld_stall, mem_write, mem_read},
                   {e_ready, e_empty, e_stall, e_write, e_read});
        end
        if (e_read) begin
          nchk++;
          if (ld_data !== e_ld) begin
            nerr++;
            $display("FAIL wrap_ld%0d: got %h want %h", i, ld_data, e_ld);
          end
        end
        acc = e_push;
        tick();
        tries++;
      end while (!acc && tries < 8);
    end
    settle();
    w0 = {mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]};
    w1 = {mem[8'h64], mem[8'h65], mem[8'h66], mem[8'h67]};
    w2 = {mem[8'h68], mem[8'h69], mem[8'h6A], mem[8'h6B]};
    nchk++;
    if ({w0, w1, w2} !== {32'h10000009, 32'h10000007, 32'h10000008}) begin
      nerr++;
      $display("FAIL wrap_order: got %h %h %h want 10000009 10000007 10000008",
               w0, w1, w2);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] acc;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hC0 + 32'(4 * i), 32'hC0C0C000 + 32'(i), 1, 32'h0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    nchk++;
    if ({mem_write, mem_addr} !== {1'b1, 32'hC0}) begin
      nerr++;
      $display("FAIL rstmid_drain: got %b %h want 1 000000c0",
               mem_write, mem_addr);
    end
    rst = 1'b1;
    #1;
    nchk++;
    if ({mem_write, empty, st_ready, ld_stall} !== 4'b0110) begin
      nerr++;
      $display("FAIL rstmid_outputs: got %b want 0110",
               {mem_write, empty, st_ready, ld_stall});
    end
    rst = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      tick();
    end
    acc = '0;
    for (int j = 0; j < 12; j++) acc |= mem[8'hC0 + 8'(j)];
    nchk++;
    if (acc !== 8'h00) begin
      nerr++;
      $display("FAIL rstmid_discard: got %h want 00", acc);
    end
  endtask

  task automatic test_random();
    bit sv, lr;
    int bad;
    for (int c = 0; c < 400; c++) begin
      sv = ($urandom % 2) == 0;
      lr = ($urandom % 2) == 0;
      drive(sv, 32'h80 + 32'($urandom_range(0, 15)), $urandom, lr,
            32'h80 + 32'($urandom_range(0, 15)));
      nchk++;
      if ({st_ready, empty, ld_stall, mem_write, mem_read}
          !== {e_ready, e_empty, e_stall, e_write, e_read}) begin
        nerr++;
        $display("FAIL rand_status@%0d: got %b want %b", c,
                 {st_ready, empty, ld_stall, mem_write, mem_read},
                 {e_ready, e_empty, e_stall, e_write, e_read});
      end
      nchk++;
      if (mem_addr !== e_addr) begin
        nerr++;
        $display("FAIL rand_addr@%0d: got %h want %h", c, mem_addr, e_addr);
      end
      if (e_write) begin
        nchk++;
        if (mem_wdata !== e_wdata) begin
          nerr++;
          $display("FAIL rand_wdata@%0d: got %h want %h", c, mem_wdata, e_wdata);
        end
      end
      if (e_read) begin
        nchk++;
        if (ld_data !== e_ld) begin
          nerr++;
          $display("FAIL rand_ld@%0d: got %h want %h", c, ld_data, e_ld);
        end
      end
      tick();
    end
    settle();
    bad = 0;
    for (int j = 8'h80; j < 8'h94; j++)
      if (mem[j] !== mref[j]) bad++;
    nchk++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL rand_mem: got %0d differing bytes want 0", bad);
    end
  endtask

  initial begin
    for (int j = 0; j < 256; j++) begin
      mem[j] = 8'h00;
      mref[j] = 8'h00;
    end
    test_reset();
    test_basic();
    test_fill();
    test_forward();
    test_overlap();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
